// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative 64x64 -> 128 unsigned shift-and-add multiplier.
// Borrows an external combinational ALU for the add step. One add-or-pass
// iteration per cycle, 64 iterations per product.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid (and its data) until that edge. Ready
// depends only on state, never on valid. Here start_ready is high exactly in
// IDLE and res_valid is high exactly in DONE.
module alu_mul_seq #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] prodHi,
   output logic [WIDTH-1:0] prodLo,
   output logic             busy,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic             alu_cIn,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] aluOut,
   input  logic             alu_cOut,
   output logic [1:0]       dbg_state
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   localparam logic [2:0] OP_PASS_B = 3'b000;
   localparam logic [2:0] OP_ADD    = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mq;
   logic [CNT_W-1:0] cnt;

   logic accept;
   logic carry;

   assign accept = (state == S_IDLE) && start_valid;
   // The carry only matters on an add step. A pass step must shift in 0.
   assign carry  = mq[0] & alu_cOut;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. start_valid is ignored outside IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept)            state_nxt = S_RUN;
         S_RUN:  if (cnt == LAST_ITER)  state_nxt = S_DONE;
         S_DONE: if (res_ready)         state_nxt = S_IDLE;
         default:                       state_nxt = S_IDLE;
      endcase
   end

   // Output decode. The ALU drive comes only from registers, so there is
   // no combinational path from aluOut back into alu_*.
   always_comb begin
      start_ready = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b0;
      alu_A       = '0;
      alu_B       = '0;
      alu_ctrl    = OP_PASS_B;
      case (state)
         S_IDLE: start_ready = 1'b1;
         S_RUN: begin
            busy     = 1'b1;
            alu_A    = mcand;
            alu_B    = acc;
            alu_ctrl = mq[0] ? OP_ADD : OP_PASS_B;
         end
         S_DONE: begin
            busy      = 1'b1;
            res_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign alu_cIn   = 1'b0;
   assign prodHi    = acc;
   assign prodLo    = mq;
   assign dbg_state = state;

   // Datapath: load on accept, then shift {carry, aluOut, mq} right by one
   // bit each RUN cycle. After the last iteration, mq holds the low half.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mcand <= '0;
         acc   <= '0;
         mq    <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  mcand <= opA;
                  mq    <= opB;
                  acc   <= '0;
                  cnt   <= '0;
               end
            end
            S_RUN: begin
               acc <= {carry, aluOut[WIDTH-1:1]};
               mq  <= {aluOut[0], mq[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed bench for alu_mul_seq, with a behavioural alu64
// attached to the ALU ports.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_valid;
   logic        start_ready;
   logic [63:0] opA;
   logic [63:0] opB;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] prodHi;
   logic [63:0] prodLo;
   logic        busy;
   logic [63:0] alu_A;
   logic [63:0] alu_B;
   logic        alu_cIn;
   logic [2:0]  alu_ctrl;
   logic [63:0] aluOut;
   logic        alu_cOut;
   logic [1:0]  dbg_state;

   logic [127:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   // clock / reset block
   always #5 clk = ~clk;

   alu_mul_seq #(.WIDTH(64)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .opA         (opA),
      .opB         (opB),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .prodHi      (prodHi),
      .prodLo      (prodLo),
      .busy        (busy),
      .alu_A       (alu_A),
      .alu_B       (alu_B),
      .alu_cIn     (alu_cIn),
      .alu_ctrl    (alu_ctrl),
      .aluOut      (aluOut),
      .alu_cOut    (alu_cOut),
      .dbg_state   (dbg_state)
   );

   // Behavioural alu64: PASS_B = 000, ADD = 010.
   logic [64:0] alu_sum;
   always_comb begin
      alu_sum = '0;
      case (alu_ctrl)
         3'b010:  alu_sum = {1'b0, alu_A} + {1'b0, alu_B} + {64'b0, alu_cIn};
         3'b000:  alu_sum = {1'b0, alu_B};
         default: alu_sum = '0;
      endcase
   end
   assign aluOut   = alu_sum[63:0];
   assign alu_cOut = alu_sum[64];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_start_ready"}, start_ready, 1);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_prod"}, {prodHi, prodLo}, 0);
      chk({tag, "_alu_ab"}, {alu_A, alu_B}, 0);
      chk({tag, "_alu_cin_ctrl"}, {alu_cIn, alu_ctrl}, 0);
   endtask

   // Driver: issue one command and consume its product. Inputs change and
   // outputs are sampled on the falling edge.
   task automatic run_cmd(input logic [63:0] a, input logic [63:0] b,
                          input bit mon_ctrl, input bit backpress);
      int k;
      logic [11:0] ctrl_seen;
      logic [127:0] held;
      bit stable;
      chk("ready_before_accept", start_ready, 1);
      start_valid = 1'b1;
      opA = a;
      opB = b;
      exp_q.push_back({64'b0, a} * {64'b0, b});
      @(negedge clk);
      start_valid = 1'b0;
      opA = $urandom();
      opB = $urandom();
      chk("busy_after_accept", busy, 1);
      k = 0;
      ctrl_seen = '0;
      while (!res_valid && k < 200) begin
         if (k < 4) ctrl_seen[3*k +: 3] = alu_ctrl;
         @(negedge clk);
         k++;
      end
      chk("latency", k, 64);
      if (mon_ctrl) chk("alu_ctrl_seq", ctrl_seen, 12'b010_000_010_000);
      if (backpress) begin
         start_valid = 1'b1;
         opA = 64'd9;
         opB = 64'd9;
         held = {prodHi, prodLo};
         stable = 1'b1;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!res_valid || start_ready || {prodHi, prodLo} !== held) stable = 1'b0;
         end
         chk("backpressure_stable", stable, 1);
         start_valid = 1'b0;
      end
      res_ready = 1'b1;
      chk("scoreboard_depth", exp_q.size(), 1);
      if (exp_q.size() != 0) chk("product", {prodHi, prodLo}, exp_q.pop_front());
      @(negedge clk);
      res_ready = 1'b0;
      chk("ready_after_consume", start_ready, 1);
      chk("valid_after_consume", res_valid, 0);
   endtask

   initial begin
      int vcount;
      reset_n     = 1'b0;
      start_valid = 1'b0;
      res_ready   = 1'b0;
      opA         = '0;
      opB         = '0;

      // reset held for two edges
      @(negedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      chk("reset_state", dbg_state, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("post_reset");

      // directed products
      run_cmd(64'd3, 64'd5, 1'b0, 1'b0);
      run_cmd(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      run_cmd(64'h8000_0000_0000_0000, 64'd2, 1'b0, 1'b0);
      run_cmd(64'h8000_0000_0000_0000, 64'hA, 1'b1, 1'b0);
      run_cmd(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b1);
      run_cmd(64'd0, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         run_cmd({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1'b0);
      end

      // mid-operation reset at iteration 30: the product is discarded
      start_valid = 1'b1;
      opA = 64'd123456;
      opB = 64'd654321;
      @(negedge clk);
      start_valid = 1'b0;
      repeat (30) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check_idle_outputs("mid_reset");
      res_ready = 1'b1;
      vcount = 0;
      for (int i = 0; i < 80; i++) begin
         if (res_valid) vcount++;
         @(negedge clk);
      end
      res_ready = 1'b0;
      chk("mid_reset_no_valid", vcount, 0);
      run_cmd(64'd7, 64'd6, 1'b0, 1'b0);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Iterative 64x64 unsigned multiplier controller that borrows a shared 64-bit ALU (carry-lookahead `alu64`) to perform shift-and-add multiplication, producing a full 128-bit product. It owns the multiplicand, accumulator and multiplier/low-product registers plus the iteration counter, and drives the ALU operand and control inputs one add-or-pass step per cycle. It sits beside the ALU in the execute stage and uses valid/ready handshakes on both the command and result sides.

## Interface
- `WIDTH`, 64: operand width. Must equal the ALU width; only 64 is supported.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `start_valid`  in  1: command valid.
- `start_ready`  out  1: command accepted when `start_valid && start_ready` at an edge.
- `opA`  in  64: multiplicand, sampled at accept.
- `opB`  in  64: multiplier, sampled at accept.
- `res_valid`  out  1: product valid.
- `res_ready`  in  1: consumer accepts the product.
- `prodHi`  out  64: product bits [127:64].
- `prodLo`  out  64: product bits [63:0].
- `busy`  out  1: high in RUN or DONE.
- `alu_A`  out  64: ALU operand A.
- `alu_B`  out  64: ALU operand B.
- `alu_cIn`  out  1: ALU carry-in. Always 0.
- `alu_ctrl`  out  3: ALU op. PASS_B = 000, ADD = 010.
- `aluOut`  in  64: ALU result, combinational from `alu_*`.
- `alu_cOut`  in  1: ALU carry-out.

## Operation
- Registers:
  - `mcand` (64), `acc` (64), `mq` (64), `cnt` (6).
  - FSM states: IDLE, RUN, DONE.
- Outputs are decoded from state:
  - `start_ready` = IDLE.
  - `res_valid` = DONE.
  - `busy` = RUN or DONE.
  - `prodHi` = `acc`, `prodLo` = `mq`.
- ALU drive in RUN: `alu_A` = `mcand`, `alu_B` = `acc`, `alu_ctrl` = ADD if `mq[0]`, else PASS_B.
- ALU drive in IDLE and DONE: `alu_A` = `alu_B` = 0, `alu_ctrl` = PASS_B.
- `alu_*` outputs depend only on registers, so there is no combinational loop through the ALU.
- IDLE:
  - On accept: `mcand` ← `opA`, `mq` ← `opB`, `acc` ← 0, `cnt` ← 0, go to RUN.
  - Without accept: hold all state.
- RUN, each cycle:
  - Carry bit `c` = `mq[0] ? alu_cOut : 0`.
  - 129-bit value {`c`, `aluOut`, `mq`} is shifted right one bit: `acc` ← {`c`, `aluOut[63:1]`}, `mq` ← {`aluOut[0]`, `mq[63:1]`}.
  - `cnt` ← `cnt` + 1.
  - When `cnt` == 63, go to DONE (exactly 64 iterations).
- Width rule: the 65-bit sum {`alu_cOut`, `aluOut`} never overflows, because `acc` < 2^64 and `mcand` < 2^64.
- DONE:
  - Hold `acc`, `mq` and the outputs stable while `res_ready` is low.
  - On `res_ready`, go to IDLE.
  - `start_valid` is ignored in RUN and DONE.
- Reset (`reset_n` low at an edge), including mid-RUN or in DONE:
  - State → IDLE; `mcand`, `acc`, `mq`, `cnt` → 0.
  - Any in-flight product is discarded with no `res_valid` pulse.
- Reset values of outputs:
  - `start_ready` = 1, `res_valid` = 0, `busy` = 0.
  - `prodHi` = `prodLo` = 0.
  - `alu_A` = `alu_B` = 0, `alu_cIn` = 0, `alu_ctrl` = 000.

## Timing
- Accept at edge T0. Iterations occur at edges T1..T64. `res_valid` rises after T64.
- Latency from accept edge to `res_valid` is 64 cycles.
- The result is consumed at the first edge Tn where `res_ready` = 1. `start_ready` rises after Tn.
- A new command can be accepted no earlier than edge Tn+1. Minimum issue interval is 66 cycles.
- A DONE→IDLE transition and a new accept never happen on the same edge.
- The ALU path must settle within one cycle: register → `alu_*` → `alu64` → `aluOut`/`alu_cOut` → register.

## Test plan
- Reset: hold `reset_n` low for 2 cycles, then check all outputs at their reset values and `start_ready` = 1 on the first cycle after release.
- `opA` = 3, `opB` = 5 → `prodHi` = 0, `prodLo` = 15. `res_valid` high exactly 64 cycles after the accept edge, and not one cycle earlier.
- `opA` = `opB` = 64'hFFFF_FFFF_FFFF_FFFF → `prodHi` = 64'hFFFF_FFFF_FFFF_FFFE, `prodLo` = 64'h0000_0000_0000_0001. Exercises `alu_cOut` capture.
- `opA` = 64'h8000_0000_0000_0000, `opB` = 2 → `prodHi` = 1, `prodLo` = 0. Then `opB` = 64'hA: monitor `alu_ctrl` over the first four RUN cycles = PASS_B, ADD, PASS_B, ADD.
- Backpressure:
  - Hold `res_ready` = 0 for 10 cycles with `start_valid` = 1 → `res_valid` and `prodHi`/`prodLo` stable, no new accept.
  - Raise `res_ready` → `start_ready` rises the following cycle.
- Mid-operation reset: assert `reset_n` = 0 at iteration 30 → IDLE, `res_valid` never pulses. A following `opA` = 7, `opB` = 6 → `prodLo` = 42, `prodHi` = 0.
